// File: rtl/uart_wb_master.sv
// UART-to-Wishbone debug bridge: decodes framed read/write commands from the uart
// byte stream and issues single 32-bit Wishbone classic transfers. Optional bus
// timeout is compiled in with `define UART_WB_MASTER_TIMEOUT_EN.
module uart_wb_master #(
  parameter int unsigned WB_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_ready_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_rd_o,
  input  logic        tx_busy_i,
  output logic        tx_wr_o,
  output logic [7:0]  tx_data_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  if (WB_TIMEOUT == 0 || WB_TIMEOUT > 65535) begin : g_bad_timeout
    $error("uart_wb_master: WB_TIMEOUT must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    BUS,
    RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE   = 8'h10;
  localparam logic [7:0] CMD_READ    = 8'h11;
  localparam logic [7:0] STATUS_OK   = 8'hA5;

`ifdef UART_WB_MASTER_TIMEOUT_EN
  localparam logic [7:0]  STATUS_TMO = 8'hEE;
  localparam logic [15:0] TMO_LAST   = 16'(WB_TIMEOUT - 1);
  logic [15:0] tmo_cnt;
`endif

  state_t      state;
  logic [1:0]  byte_cnt;
  logic        is_read;
  logic [31:0] rd_data;
  logic [7:0]  status;
  logic [2:0]  resp_idx;
  logic [2:0]  resp_last;
  logic        accept;

  // A pop is requested one cycle ahead; the byte is captured while rx_rd_o is high,
  // so back-to-back pops are impossible and the core has a cycle to clear ready.
  assign accept = rx_ready_i && !rx_rd_o && (state inside {IDLE, ADDR, WDATA});
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      is_read   <= 1'b0;
      rd_data   <= '0;
      status    <= '0;
      resp_idx  <= '0;
      resp_last <= '0;
      rx_rd_o   <= 1'b0;
      tx_wr_o   <= 1'b0;
      tx_data_o <= '0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch reads
      // the pre-edge values; blocking would make the result depend on statement order.
      rx_rd_o <= accept;
      tx_wr_o <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_rd_o && (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ)) begin
            is_read  <= rx_data_i[0];
            byte_cnt <= 2'd0;
            state    <= ADDR;
          end
        end

        ADDR: begin
          if (rx_rd_o) begin
            wb_addr_o <= {wb_addr_o[23:0], rx_data_i};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_read) begin
                state    <= BUS;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_sel_o <= 4'hF;
                wb_we_o  <= 1'b0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
                tmo_cnt  <= '0;
`endif
              end else begin
                state <= WDATA;
              end
            end
          end
        end

        WDATA: begin
          if (rx_rd_o) begin
            wb_data_o <= {wb_data_o[23:0], rx_data_i};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= BUS;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_sel_o <= 4'hF;
              wb_we_o  <= 1'b1;
`ifdef UART_WB_MASTER_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
            end
          end
        end

        BUS: begin
          if (wb_ack_i) begin
            if (is_read) rd_data <= wb_data_i;
            status    <= STATUS_OK;
            resp_last <= is_read ? 3'd4 : 3'd0;
            resp_idx  <= 3'd0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'h0;
            state     <= RESP;
          end
`ifdef UART_WB_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            // Timed-out reads still answer with the single error byte only.
            status    <= STATUS_TMO;
            resp_last <= 3'd0;
            resp_idx  <= 3'd0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'h0;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end

        RESP: begin
          if (!tx_busy_i && !tx_wr_o) begin
            tx_wr_o <= 1'b1;
            if (resp_idx == 3'd0) begin
              tx_data_o <= status;
            end else begin
              tx_data_o <= rd_data[31:24];
              rd_data   <= {rd_data[23:0], 8'h00};
            end
            resp_idx <= resp_idx + 3'd1;
            if (resp_idx == resp_last) state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: uart/slave models, scoreboard queues for
// expected bus transfers and transmit bytes, directed steps in one initial block.
module tb_uart_wb_master;

`ifdef UART_WB_MASTER_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 1024;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rd;
  logic        tx_busy = 1'b0;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic [31:0] wb_addr, wb_wdata;
  logic [31:0] wb_rdata = 32'h0;
  logic        wb_we, wb_stb, wb_cyc;
  logic [3:0]  wb_sel;
  logic        wb_ack = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  exp_tx[$];
  bus_t        exp_bus[$];
  logic [31:0] rd_q[$];

  int   slave_waits = 0;
  logic no_ack      = 1'b0;
  logic force_busy  = 1'b0;
  int   wcnt        = 0;
  int   busy_cnt    = 0;
  logic rd_pending  = 1'b0;
  logic prev_txwr   = 1'b0;
  logic prev_cyc    = 1'b0;
  int   cyc_len     = 0;
  int   last_cyc_len = 0;
  int   tx_count    = 0;
  bus_t cur;

  uart_wb_master #(.WB_TIMEOUT(TMO)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_ready_i (rx_ready),
    .rx_data_i  (rx_data),
    .rx_rd_o    (rx_rd),
    .tx_busy_i  (tx_busy),
    .tx_wr_o    (tx_wr),
    .tx_data_o  (tx_data),
    .wb_addr_o  (wb_addr),
    .wb_data_o  (wb_wdata),
    .wb_data_i  (wb_rdata),
    .wb_we_o    (wb_we),
    .wb_sel_o   (wb_sel),
    .wb_stb_o   (wb_stb),
    .wb_cyc_o   (wb_cyc),
    .wb_ack_i   (wb_ack),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Models and monitors, all sampled on the falling edge.
  always @(negedge clk) begin
    // transmit monitor: strobe only after a non-busy cycle and never back to back
    if (tx_wr) begin
      tx_count++;
      check("tx_expected_pending", 64'(exp_tx.size() != 0), 64'd1);
      if (exp_tx.size() != 0) check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
      check("tx_spacing", {62'd0, tx_busy, prev_txwr}, 64'd0);
    end
    prev_txwr = tx_wr;

    // uart transmitter busy model with one-cycle latency
    if (tx_wr) busy_cnt = 5;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = force_busy || (busy_cnt != 0);

    // uart receiver model: byte leaves the buffer after the capture edge
    if (rd_pending && rxq.size() != 0) void'(rxq.pop_front());
    rd_pending = rx_rd;
    rx_ready   = (rxq.size() != 0);
    rx_data    = (rxq.size() != 0) ? rxq[0] : 8'h00;

    // bus monitor
    if (wb_cyc) begin
      if (!prev_cyc) begin
        check("bus_expected_pending", 64'(exp_bus.size() != 0), 64'd1);
        if (exp_bus.size() != 0) begin
          cur = exp_bus.pop_front();
          check("bus_addr", 64'(wb_addr), 64'(cur.addr));
          check("bus_we", 64'(wb_we), 64'(cur.we));
          check("bus_sel_stb", {59'd0, wb_sel, wb_stb}, {59'd0, 4'hF, 1'b1});
          if (cur.we) check("bus_wdata", 64'(wb_wdata), 64'(cur.data));
        end
        cyc_len = 0;
      end else if (wb_addr !== cur.addr || wb_stb !== 1'b1) begin
        check("bus_stable", {wb_addr, 31'd0, wb_stb}, {cur.addr, 31'd0, 1'b1});
      end
      cyc_len++;
    end else if (prev_cyc) begin
      last_cyc_len = cyc_len;
    end
    prev_cyc = wb_cyc;

    // Wishbone slave model
    wb_ack = 1'b0;
    if (!wb_cyc) begin
      wcnt = 0;
    end else if (wb_stb && !no_ack) begin
      if (wcnt == slave_waits) begin
        wb_ack   = 1'b1;
        wb_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hBAD0BAD0;
        wcnt     = 0;
      end else begin
        wcnt++;
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) rxq.push_back(w[i*8 +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    bus_t e;
    @(posedge clk); #1;
    e.addr = a; e.data = d; e.we = 1'b1;
    exp_bus.push_back(e);
    exp_tx.push_back(8'hA5);
    rxq.push_back(8'h10);
    push_word(a);
    push_word(d);
  endtask

  task automatic send_read(input logic [31:0] a, input logic [31:0] d, input bit respond);
    bus_t e;
    @(posedge clk); #1;
    e.addr = a; e.data = 32'h0; e.we = 1'b0;
    exp_bus.push_back(e);
    if (respond) begin
      rd_q.push_back(d);
      exp_tx.push_back(8'hA5);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
    end
    rxq.push_back(8'h11);
    push_word(a);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_tx.size() == 0) && (exp_bus.size() == 0) && (rxq.size() == 0)
             && !busy && !wb_cyc && !tx_busy;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_cyc(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = wb_cyc;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check({tag, "_cyc_stb_async"}, {62'd0, wb_cyc, wb_stb}, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int tx_before;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {rx_rd, tx_wr, tx_data, wb_we, wb_sel, wb_stb, wb_cyc, busy},
          64'd0);
    check("reset_bus_regs", {wb_addr, wb_wdata}, 64'd0);
    rst = 1'b0;

    // write, slave acks after 2 wait cycles
    slave_waits = 2;
    send_write(32'h0000_1004, 32'hDEAD_BEEF);
    wait_idle("write_done", 2000);
    check("write_cyc_len", 64'(last_cyc_len), 64'd3);

    // read with 3 wait cycles
    slave_waits = 3;
    send_read(32'h0000_0020, 32'h1234_5678, 1'b1);
    wait_idle("read_done", 2000);
    check("read_cyc_len", 64'(last_cyc_len), 64'd4);

    // resync: junk bytes are discarded without a bus cycle
    slave_waits = 1;
    @(posedge clk); #1;
    rxq.push_back(8'h55);
    rxq.push_back(8'hFF);
    send_read(32'h0000_0004, 32'hCAFE_F00D, 1'b1);
    wait_idle("resync_read_done", 2000);

    // transmitter held busy through the read response
    force_busy = 1'b1;
    slave_waits = 0;
    tx_before = tx_count;
    send_read(32'h0000_0100, 32'hA1B2_C3D4, 1'b1);
    cnt = 0;
    while ((exp_bus.size() != 0 || wb_cyc) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("busy_bus_done", 64'(cnt < 500), 64'd1);
    repeat (200) @(negedge clk);
    check("no_tx_while_busy", 64'(tx_count), 64'(tx_before));
    check("busy_o_in_resp", 64'(busy), 64'd1);
    force_busy = 1'b0;
    wait_idle("busy_read_done", 2000);
    check("busy_tx_count", 64'(tx_count - tx_before), 64'd5);

    // reset in the middle of a bus cycle, then a fresh write
    no_ack = 1'b1;
    send_read(32'h0000_0040, 32'h0, 1'b0);
    wait_cyc("rst_test_cyc_start", 200);
    repeat (5) @(negedge clk);
    pulse_reset("midcycle_rst");
    no_ack = 1'b0;
    slave_waits = 0;
    send_write(32'hFFFF_FFFC, 32'h0123_4567);
    wait_idle("post_rst_write_done", 2000);
    check("post_rst_cyc_len", 64'(last_cyc_len), 64'd1);

    // unacknowledged read: timeout build answers EE, default build waits forever
    no_ack = 1'b1;
`ifdef UART_WB_MASTER_TIMEOUT_EN
    send_read(32'h0000_0080, 32'h0, 1'b0);
    @(posedge clk); #1;
    exp_tx.push_back(8'hEE);
    wait_idle("timeout_done", 2000);
    check("timeout_cyc_len", 64'(last_cyc_len), 64'(TMO));
`else
    send_read(32'h0000_0080, 32'h0, 1'b0);
    wait_cyc("noack_cyc_start", 200);
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (wb_cyc) cnt++;
    end
    check("noack_cyc_held", 64'(cnt), 64'd1100);
    check("noack_no_tx", 64'(exp_tx.size()), 64'd0);
    pulse_reset("noack_rst");
`endif
    no_ack = 1'b0;

    repeat (20) @(negedge clk);
    check("final_queues_empty", {32'(exp_tx.size()), 32'(exp_bus.size())}, 64'd0);
    check("final_idle", {62'd0, busy, wb_cyc}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_wb_master.md
Name:
uart_wb_master

Overview:
- Debug bridge that lets a host PC act as Wishbone bus initiator over a serial link.
- Sits between the byte interface of the existing `uart` core (instantiated externally) and a Wishbone classic master port.
- Decodes framed read/write commands from the UART receive byte stream.
- Issues single 32-bit Wishbone transfers and returns status and read data through the UART transmit side.

Parameters:
- WB_TIMEOUT, 1024: bus-cycle timeout in clk_i cycles; used only when the optional feature is compiled in. Legal range 1..65535.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; asynchronous, active-high
- rx_ready_i  input  1  uart core has a received byte
- rx_data_i  input  8  received byte, valid while rx_ready_i=1
- rx_rd_o  output  1  one-cycle pop of the received byte
- tx_busy_i  input  1  uart core transmitter busy
- tx_wr_o  output  1  one-cycle transmit strobe
- tx_data_o  output  8  byte to transmit, valid with tx_wr_o
- wb_addr_o  output  32  Wishbone address
- wb_data_o  output  32  Wishbone write data
- wb_data_i  input  32  Wishbone read data
- wb_we_o  output  1  write enable
- wb_sel_o  output  4  byte selects
- wb_stb_o  output  1  strobe
- wb_cyc_o  output  1  cycle
- wb_ack_i  input  1  acknowledge
- busy_o  output  1  high whenever the state is not IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, all shift and capture registers 0.
- Frame format, all multi-byte fields big-endian, MSB first:
  - Write frame: 0x10, A[31:24], A[23:16], A[15:8], A[7:0], D[31:24]..D[7:0].
  - Read frame: 0x11, A[31:24]..A[7:0].
- Receive byte handling:
  - A byte is consumed when rx_ready_i=1 and the state accepts input: rx_rd_o=1 for one cycle and rx_data_i is captured in that same cycle.
  - No pop in the cycle immediately after a pop. This allows the core's rx_ready_o to clear.
- States and transitions:
  - IDLE: pops the command byte. 0x10 or 0x11 -> ADDR with the byte counter cleared. Any other value is discarded and the state stays IDLE; this is the resync mechanism.
  - ADDR: shifts in 4 bytes. After the 4th byte: write -> WDATA; read -> BUS.
  - WDATA: shifts in 4 bytes. After the 4th byte -> BUS.
  - BUS:
    - On entry, wb_cyc_o=wb_stb_o=1 in the cycle after the last byte pop, with wb_sel_o=4'hF and wb_we_o=1 for write.
    - wb_addr_o and wb_data_o are held stable for the whole cycle.
    - On wb_ack_i=1: wb_data_i is latched if reading, then in the next cycle cyc, stb and we return to 0 and the state goes to RESP.
    - The block has no burst or pipelined mode, and no retry.
  - RESP:
    - Queues the status byte 0xA5, followed by read-data bytes D[31:24]..D[7:0] for reads only.
    - A write response is 1 byte; a read response is 5 bytes.
    - After the last byte -> IDLE.
- Transmit handling:
  - tx_wr_o pulses one cycle only when tx_busy_i=0, and never in the cycle directly after a tx_wr_o. This covers the core's one-cycle busy latency.
  - tx_data_o is stable during the pulse.
  - Bytes are never dropped or reordered while tx_busy_i stays high.
- Receive bytes arriving during BUS or RESP are not popped; they stay buffered in the uart core.
- Byte counter: 2 bits, wraps 3->0 at field end.
- wb_ack_i outside BUS is ignored.
- rst_i asserted at any point, including mid bus cycle: cyc and stb drop immediately (asynchronously), the state goes to IDLE, and the partial frame is lost.

Optional Feature:
- Macro: UART_WB_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on BUS entry and increments each BUS cycle without ack.
  - On reaching WB_TIMEOUT: cyc and stb go to 0 the next cycle, and the response is the single byte 0xEE (no data bytes, even for reads).
  - An ack in the same cycle as the timeout wins, giving a normal 0xA5 response.
- Without the macro: no counter logic; BUS waits indefinitely for wb_ack_i.

Test Plan:
- Write frame 10 00 00 10 04 DE AD BE EF, slave acks after 2 waits -> exactly one cycle with addr=0x00001004, data=0xDEADBEEF, we=1, sel=F; tx emits single byte A5; busy_o back to 0.
- Read frame 11 00 00 00 20, slave returns 0x12345678 after 3 waits -> we=0 cycle at 0x00000020; tx emits A5 12 34 56 78 in order.
- Bytes 55 FF, then read frame for 0x00000004 -> 55 and FF discarded, no bus cycle for them; read completes normally with A5 plus 4 data bytes.
- tx_busy_i forced high 200 cycles during a read response -> no tx_wr_o while high, then all 5 bytes sent, no duplicates, at least one idle cycle between strobes.
- rst_i pulsed while wb_cyc_o=1 -> wb_cyc_o and wb_stb_o low in the same cycle; after release a fresh write frame completes normally.
- With UART_WB_MASTER_TIMEOUT_EN and WB_TIMEOUT=16, read with no ack -> cyc drops after 16 cycles, tx emits only EE; without the macro, cyc stays high for 1000+ cycles.
